// File: rtl/lfsr_datapath.sv
// Fibonacci LFSR datapath: seed load, prescaled stepping, and period measurement
// by detecting the return of the register to its loaded seed.
module lfsr_datapath #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               DIV          = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shload,
  input  logic             running,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             step,
  output logic             wrapped,
  output logic [WIDTH:0]   period,
  output logic             seed_zero
);

  localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   CNT_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   CNT_MAX = {(WIDTH+1){1'b1}};

  logic [WIDTH-1:0] lfsr_q,      lfsr_d;
  logic [WIDTH-1:0] start_q,     start_d;
  logic [WIDTH:0]   cnt_q,       cnt_d;
  logic [PRE_W-1:0] pre_q,       pre_d;
  logic [WIDTH:0]   period_q,    period_d;
  logic             seed_zero_q, seed_zero_d;
  logic             step_q,      step_d;
  logic             wrapped_q,   wrapped_d;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH:0]   cnt_inc_s;

  function automatic logic feedback_parity(input logic [WIDTH-1:0] v);
    return ^(v & TAPS);
  endfunction

  // Next-state logic: load beats a run tick; hold keeps every register.
  always_comb begin
    lfsr_d      = lfsr_q;
    start_d     = start_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    period_d    = period_q;
    seed_zero_d = seed_zero_q;
    step_d      = 1'b0;
    wrapped_d   = 1'b0;
    shifted_s   = {lfsr_q[WIDTH-2:0], feedback_parity(lfsr_q)};
    cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    if (shload) begin
      if (seed == {WIDTH{1'b0}}) begin
        lfsr_d      = DEFAULT_SEED;
        start_d     = DEFAULT_SEED;
        seed_zero_d = 1'b1;
      end else begin
        lfsr_d      = seed;
        start_d     = seed;
        seed_zero_d = 1'b0;
      end
      cnt_d = {(WIDTH+1){1'b0}};
      pre_d = {PRE_W{1'b0}};
    end else if (running) begin
      if (pre_q != PRE_MAX) begin
        pre_d = pre_q + PRE_ONE;
      end else begin
        pre_d  = {PRE_W{1'b0}};
        lfsr_d = shifted_s;
        step_d = 1'b1;
        if (shifted_s == start_q) begin
          wrapped_d = 1'b1;
          period_d  = cnt_inc_s;
          cnt_d     = {(WIDTH+1){1'b0}};
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q      <= DEFAULT_SEED;
      start_q     <= DEFAULT_SEED;
      cnt_q       <= {(WIDTH+1){1'b0}};
      pre_q       <= {PRE_W{1'b0}};
      period_q    <= {(WIDTH+1){1'b0}};
      seed_zero_q <= 1'b0;
      step_q      <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      period_q    <= period_d;
      seed_zero_q <= seed_zero_d;
      step_q      <= step_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign q         = lfsr_q;
  assign bit_out   = lfsr_q[WIDTH-1];
  assign step      = step_q;
  assign wrapped   = wrapped_q;
  assign period    = period_q;
  assign seed_zero = seed_zero_q;

endmodule

// File: tb/tb_lfsr_datapath.sv
// Bench for lfsr_datapath: two instances (DIV=1 and DIV=3) driven in lockstep,
// directed scenarios plus random stimulus against a behavioural model.
module tb_lfsr_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       shload = 1'b0;
  logic       running = 1'b0;
  logic [3:0] seed = 4'd0;

  logic [3:0] q1, q3;
  logic       bit1, bit3, step1, step3, wrap1, wrap3, sz1, sz3;
  logic [4:0] per1, per3;

  int n_checks = 0;
  int n_fail   = 0;

  int m_q[2], m_start[2], m_cnt[2], m_pre[2], m_period[2];
  int m_sz[2], m_step[2], m_wrap[2];
  int m_div[2] = '{1, 3};

  always #5 clk = ~clk;

  lfsr_datapath #(.WIDTH(4), .TAPS(4'b1001), .DEFAULT_SEED(4'b0001), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .shload(shload), .running(running), .seed(seed),
    .q(q1), .bit_out(bit1), .step(step1), .wrapped(wrap1), .period(per1), .seed_zero(sz1)
  );

  lfsr_datapath #(.WIDTH(4), .TAPS(4'b1001), .DEFAULT_SEED(4'b0001), .DIV(3)) dut3 (
    .clk(clk), .reset(reset), .shload(shload), .running(running), .seed(seed),
    .q(q3), .bit_out(bit3), .step(step3), .wrapped(wrap3), .period(per3), .seed_zero(sz3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    int fb;
    fb = $countones(v & 9) % 2;
    return ((v * 2) + fb) % 16;
  endfunction

  // Behavioural model of one edge for instance k.
  task automatic model_edge(input int k, input bit rst, input bit ld, input bit run, input int sd);
    m_step[k] = 0;
    m_wrap[k] = 0;
    if (rst) begin
      m_q[k] = 1; m_start[k] = 1; m_cnt[k] = 0; m_pre[k] = 0; m_period[k] = 0; m_sz[k] = 0;
    end else if (ld) begin
      m_sz[k]    = (sd == 0) ? 1 : 0;
      m_q[k]     = (sd == 0) ? 1 : sd;
      m_start[k] = m_q[k];
      m_cnt[k]   = 0;
      m_pre[k]   = 0;
    end else if (run) begin
      if (m_pre[k] < m_div[k] - 1) begin
        m_pre[k]++;
      end else begin
        m_pre[k]  = 0;
        m_q[k]    = lfsr_next(m_q[k]);
        m_step[k] = 1;
        if (m_q[k] == m_start[k]) begin
          m_wrap[k]   = 1;
          m_period[k] = (m_cnt[k] + 1 > 31) ? 31 : m_cnt[k] + 1;
          m_cnt[k]    = 0;
        end else begin
          m_cnt[k] = (m_cnt[k] + 1 > 31) ? 31 : m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic compare_inst(input string nm, input int k, input logic [3:0] q, input logic b,
                              input logic s, input logic w, input logic [4:0] p, input logic z);
    check({nm, ".q"},         32'(q), 32'(m_q[k]));
    check({nm, ".bit_out"},   32'(b), 32'((m_q[k] / 8) % 2));
    check({nm, ".step"},      32'(s), 32'(m_step[k]));
    check({nm, ".wrapped"},   32'(w), 32'(m_wrap[k]));
    check({nm, ".period"},    32'(p), 32'(m_period[k]));
    check({nm, ".seed_zero"}, 32'(z), 32'(m_sz[k]));
  endtask

  task automatic cycle(input bit rst, input bit ld, input bit run, input logic [3:0] sd);
    reset = rst; shload = ld; running = run; seed = sd;
    @(posedge clk);
    model_edge(0, rst, ld, run, int'(sd));
    model_edge(1, rst, ld, run, int'(sd));
    #1;
    compare_inst("div1", 0, q1, bit1, step1, wrap1, per1, sz1);
    compare_inst("div3", 1, q3, bit3, step3, wrap3, per3, sz3);
  endtask

  int wraps;
  logic [3:0] exp_seq [3] = '{4'd3, 4'd7, 4'd15};

  initial begin
    // Reset
    cycle(1'b1, 1'b0, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0);
    check("reset_q", 32'(q1), 32'd1);
    check("reset_period", 32'(per1), 32'd0);
    check("reset_seed_zero", 32'(sz1), 32'd0);
    check("reset_step", 32'(step1), 32'd0);
    check("reset_wrapped", 32'(wrap1), 32'd0);

    // Load 0001 and step three times
    cycle(1'b0, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      check("load_step_q", 32'(q1), 32'(exp_seq[i]));
      check("load_step_pulse", 32'(step1), 32'd1);
    end

    // Complete the first period, then a second one
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      wraps += int'(wrap1);
    end
    check("period1_wraps", 32'(wraps), 32'd1);
    check("period1_q", 32'(q1), 32'd1);
    check("period1_wrapped_now", 32'(wrap1), 32'd1);
    check("period1_value", 32'(per1), 32'd15);
    wraps = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      wraps += int'(wrap1);
    end
    check("period2_wraps", 32'(wraps), 32'd1);
    check("period2_value", 32'(per1), 32'd15);

    // Zero seed substitution, then a nonzero load clears the flag
    cycle(1'b0, 1'b1, 1'b0, 4'd0);
    check("zero_seed_q", 32'(q1), 32'd1);
    check("zero_seed_flag", 32'(sz1), 32'd1);
    check("zero_seed_period_kept", 32'(per1), 32'd15);
    cycle(1'b0, 1'b1, 1'b0, 4'd5);
    check("reload_q", 32'(q1), 32'd5);
    check("reload_flag", 32'(sz1), 32'd0);

    // Prescaler with pause on the DIV=3 instance
    cycle(1'b0, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      check("presc_run_hold_q", 32'(q3), 32'd1);
      check("presc_run_no_step", 32'(step3), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd0);
      check("presc_idle_q", 32'(q3), 32'd1);
    end
    cycle(1'b0, 1'b0, 1'b1, 4'd0);
    check("presc_shift_q", 32'(q3), 32'd3);
    check("presc_shift_step", 32'(step3), 32'd1);

    // Priority: load beats running; reset beats running
    cycle(1'b0, 1'b1, 1'b1, 4'd10);
    check("prio_load_q", 32'(q1), 32'd10);
    check("prio_load_no_step", 32'(step1), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0);
    cycle(1'b1, 1'b0, 1'b1, 4'd0);
    check("prio_reset_q", 32'(q1), 32'd1);
    check("prio_reset_period", 32'(per1), 32'd0);

    // Randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(23) == 0),
            ($urandom_range(3) != 0), 4'($urandom_range(15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
